// File: rtl/bidi_mod_counter.sv
// Bidirectional counter over [MIN_VAL..MAX_VAL] with a configurable step, wrap or saturate
// mode, parallel load and per-direction terminal-count pulses. Define BIDICNTR_STICKY_EN for sticky flags.
module bidi_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 2**WIDTH-1,
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ctrl,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc_up,
    output logic             tc_dn,
    output logic             ovf_sticky,
    output logic             unf_sticky
);

    // Two guard bits keep count+STEP and count+span free of overflow.
    localparam int XW = WIDTH + 2;

    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
    localparam logic [XW-1:0]    MIN_X  = XW'(MIN_VAL);
    localparam logic [XW-1:0]    MAX_X  = XW'(MAX_VAL);
    localparam logic [XW-1:0]    STEP_X = XW'(STEP);
    localparam logic [XW-1:0]    SPAN_X = XW'(MAX_VAL - MIN_VAL + 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_up_q, tc_up_d;
    logic             tc_dn_q, tc_dn_d;

    logic [XW-1:0]    cnt_x;
    logic [XW-1:0]    up_sum;
    logic [XW-1:0]    up_wrap;
    logic [XW-1:0]    dn_diff;
    logic [XW-1:0]    dn_wrap;
    logic             up_over;
    logic             dn_under;
    logic             load_below;
    logic             load_above;
    logic [WIDTH-1:0] load_clamped;

    assign cnt_x    = {2'b00, count_q};
    assign up_sum   = cnt_x + STEP_X;
    assign up_over  = up_sum > MAX_X;
    assign up_wrap  = up_sum + MIN_X - MAX_X - XW'(1);
    assign dn_under = cnt_x < (MIN_X + STEP_X);
    assign dn_diff  = cnt_x - STEP_X;
    assign dn_wrap  = cnt_x + SPAN_X - STEP_X;

    // Bounds at the edge of the WIDTH-bit range can never be crossed by load_val.
    generate
        if (MIN_VAL == 0) begin : g_no_min_clamp
            assign load_below = 1'b0;
        end else begin : g_min_clamp
            assign load_below = load_val < MIN_W;
        end
        if (MAX_VAL == 2**WIDTH-1) begin : g_no_max_clamp
            assign load_above = 1'b0;
        end else begin : g_max_clamp
            assign load_above = load_val > MAX_W;
        end
    endgenerate

    always_comb begin
        load_clamped = load_val;
        if (load_below) begin
            load_clamped = MIN_W;
        end else if (load_above) begin
            load_clamped = MAX_W;
        end
    end

    always_comb begin
        count_d = count_q;
        tc_up_d = 1'b0;
        tc_dn_d = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            if (ctrl) begin
                if (!up_over) begin
                    count_d = up_sum[WIDTH-1:0];
                end else if (sat) begin
                    count_d = MAX_W;
                    tc_up_d = count_q != MAX_W;
                end else begin
                    count_d = up_wrap[WIDTH-1:0];
                    tc_up_d = 1'b1;
                end
            end else begin
                if (!dn_under) begin
                    count_d = dn_diff[WIDTH-1:0];
                end else if (sat) begin
                    count_d = MIN_W;
                    tc_dn_d = count_q != MIN_W;
                end else begin
                    count_d = dn_wrap[WIDTH-1:0];
                    tc_dn_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= MIN_W;
            tc_up_q <= 1'b0;
            tc_dn_q <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_up_q <= tc_up_d;
            tc_dn_q <= tc_dn_d;
        end
    end

    assign count  = count_q;
    assign tc_up  = tc_up_q;
    assign tc_dn  = tc_dn_q;
    assign at_max = count_q == MAX_W;
    assign at_min = count_q == MIN_W;

`ifdef BIDICNTR_STICKY_EN
    logic ovf_sticky_q, ovf_sticky_d;
    logic unf_sticky_q, unf_sticky_d;

    // A boundary event in the same cycle as clr_flags leaves the flag set.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        unf_sticky_d = unf_sticky_q;
        if (clr_flags) begin
            ovf_sticky_d = 1'b0;
            unf_sticky_d = 1'b0;
        end
        if (tc_up_d) begin
            ovf_sticky_d = 1'b1;
        end
        if (tc_dn_d) begin
            unf_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;
`else
    logic unused_clr_flags;
    assign unused_clr_flags = clr_flags;
    assign ovf_sticky       = 1'b0;
    assign unf_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_bidi_mod_counter.sv
// Scoreboard bench: two counter configurations share one stimulus stream; an arithmetic
// reference model queues the expected state and a monitor compares after each clock edge.
module tb_bidi_mod_counter;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tu;
        logic       td;
        logic       amax;
        logic       amin;
        logic       ovf;
        logic       unf;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       ctrl = 1'b0;
    logic       sat = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       clr_flags = 1'b0;

    logic [3:0] count0, count1;
    logic       at_max0, at_min0, tc_up0, tc_dn0, ovf0, unf0;
    logic       at_max1, at_min1, tc_up1, tc_dn1, ovf1, unf1;

    int errors = 0;
    int checks = 0;
    int cyc_no = 0;
    pair_t sb_q[$];

    int mc[2];
    bit mov[2];
    bit mun[2];

    always #5 clk = ~clk;

    bidi_mod_counter #(.WIDTH(4)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .ctrl(ctrl), .sat(sat), .load(load),
        .load_val(load_val), .clr_flags(clr_flags), .count(count0), .at_max(at_max0),
        .at_min(at_min0), .tc_up(tc_up0), .tc_dn(tc_dn0), .ovf_sticky(ovf0), .unf_sticky(unf0)
    );

    bidi_mod_counter #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(12), .STEP(5)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .ctrl(ctrl), .sat(sat), .load(load),
        .load_val(load_val), .clr_flags(clr_flags), .count(count1), .at_max(at_max1),
        .at_min(at_min1), .tc_up(tc_up1), .tc_dn(tc_dn1), .ovf_sticky(ovf1), .unf_sticky(unf1)
    );

    // Reference: plain integer arithmetic, wrap expressed as a modulo over the range span.
    function automatic exp_t model(int k, int mn, int mx, int st);
        int c = mc[k];
        int n = c;
        int span = mx - mn + 1;
        int lv = int'(load_val);
        bit tu = 1'b0;
        bit td = 1'b0;
        exp_t e;
        if (reset) begin
            n = mn;
            mov[k] = 1'b0;
            mun[k] = 1'b0;
        end else begin
            if (load) begin
                n = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
            end else if (en && ctrl) begin
                if (c + st <= mx) n = c + st;
                else if (sat) begin n = mx; tu = (c < mx); end
                else begin n = mn + ((c - mn + st) % span); tu = 1'b1; end
            end else if (en) begin
                if (c - st >= mn) n = c - st;
                else if (sat) begin n = mn; td = (c > mn); end
                else begin n = mn + ((c - mn - st + span) % span); td = 1'b1; end
            end
`ifdef BIDICNTR_STICKY_EN
            if (tu) mov[k] = 1'b1;
            else if (clr_flags) mov[k] = 1'b0;
            if (td) mun[k] = 1'b1;
            else if (clr_flags) mun[k] = 1'b0;
`endif
        end
        mc[k] = n;
        e.cnt  = 4'(n);
        e.tu   = tu;
        e.td   = td;
        e.amax = (n == mx);
        e.amin = (n == mn);
        e.ovf  = mov[k];
        e.unf  = mun[k];
        return e;
    endfunction

    task automatic cyc(input logic r, input logic e, input logic c, input logic s,
                       input logic l, input logic [3:0] lv, input logic cf);
        pair_t p;
        @(negedge clk);
        reset = r; en = e; ctrl = c; sat = s; load = l; load_val = lv; clr_flags = cf;
        p.a = model(0, 0, 15, 1);
        p.b = model(1, 3, 12, 5);
        sb_q.push_back(p);
    endtask

    task automatic compare(input int idx, input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL dut%0d cycle %0d: got cnt=%0d tc_up=%b tc_dn=%b at_max=%b at_min=%b ovf=%b unf=%b, expected cnt=%0d tc_up=%b tc_dn=%b at_max=%b at_min=%b ovf=%b unf=%b",
                     idx, cyc_no, got.cnt, got.tu, got.td, got.amax, got.amin, got.ovf, got.unf,
                     exp.cnt, exp.tu, exp.td, exp.amax, exp.amin, exp.ovf, exp.unf);
        end
    endtask

    // Monitor: the DUT presents a new state after every edge.
    initial begin
        pair_t p;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                p = sb_q.pop_front();
                cyc_no++;
                compare(0, {count0, tc_up0, tc_dn0, at_max0, at_min0, ovf0, unf0}, p.a);
                compare(1, {count1, tc_up1, tc_dn1, at_max1, at_min1, ovf1, unf1}, p.b);
                $display("cycle %0d: cnt0=%0d cnt1=%0d tc_up=%b/%b tc_dn=%b/%b ovf=%b/%b unf=%b/%b",
                         cyc_no, count0, count1, tc_up0, tc_up1, tc_dn0, tc_dn1, ovf0, ovf1, unf0, unf1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then count up through one wrap.
        repeat (2) cyc(1, 0, 0, 0, 0, 4'd0, 0);
        repeat (17) cyc(0, 1, 1, 0, 0, 4'd0, 0);
        // Saturating countdown from 2.
        cyc(0, 0, 0, 0, 1, 4'd2, 0);
        repeat (5) cyc(0, 1, 0, 1, 0, 4'd0, 0);
        // Load 10, wrap up, then down twice (second one wraps in the offset range).
        cyc(0, 0, 0, 0, 1, 4'd10, 0);
        repeat (2) cyc(0, 1, 1, 0, 0, 4'd0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0, 4'd0, 0);
        // Load beats enable and clamps; reset beats load.
        cyc(0, 1, 1, 0, 1, 4'd14, 0);
        cyc(1, 1, 1, 0, 1, 4'd14, 0);
        // Reset mid-count, then resume.
        repeat (9) cyc(0, 1, 1, 0, 0, 4'd0, 0);
        cyc(1, 1, 1, 0, 0, 4'd0, 0);
        repeat (3) cyc(0, 1, 1, 0, 0, 4'd0, 0);
        // Sticky flags: wrap, hold, clear, then wrap coincident with clear.
        cyc(0, 0, 0, 0, 1, 4'd15, 0);
        cyc(0, 1, 1, 0, 0, 4'd0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0, 4'd0, 0);
        cyc(0, 0, 0, 0, 0, 4'd0, 1);
        cyc(0, 0, 0, 0, 1, 4'd15, 0);
        cyc(0, 1, 1, 0, 0, 4'd0, 1);
        cyc(0, 1, 0, 0, 1, 4'd0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 4'd0, 0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                1'($urandom), ($urandom_range(0, 9) == 0), 4'($urandom), ($urandom_range(0, 7) == 0));
        end
        cyc(0, 0, 0, 0, 0, 4'd0, 0);
        for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left in scoreboard, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
